sm_reg_scanner: RTL and testbench

- Reader-side master for the CPU debug register access port: drives regAddr and samples regData.
- On a start pulse it walks a window of register addresses and captures each value.
- Each captured value is streamed out on a valid/ready interface, for a UART dumper or a trace buffer.
- Sits beside sm_cpu at the top level, in place of board switches on regAddr.

---
 rtl/sm_reg_scanner.sv | 75 +++++++
 tb/tb_sm_reg_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_scanner.sv
// sm_reg_scanner: debug-port register window scanner streaming captured words; SM_SCAN_DELTA_EN emits only changed words
module sm_reg_scanner #(
  parameter int FIRST_REG = 0,
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        continuous,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        outValid,
  input  logic        outReady,
  output logic [4:0]  outAddr,
  output logic [31:0] outData,
  output logic        outLast,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SETUP, OUT} state_t;
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST = 5'(FIRST_REG + REG_COUNT - 1);
  state_t r_state;
  logic w_skip, w_last, w_adv, w_cap;
  assign w_last = regAddr == LAST;
  assign w_adv = (r_state == SETUP && w_skip) || (r_state == OUT && outReady);
  assign w_cap = r_state == SETUP && !w_skip;
  assign busy = r_state != IDLE;
`ifdef SM_SCAN_DELTA_EN
  logic [31:0] r_shadow [32];
  logic [31:0] r_sv;
  assign w_skip = r_sv[regAddr] && r_shadow[regAddr] == regData;
  always_ff @(posedge clk)
    if (w_cap && !abort) r_shadow[regAddr] <= regData;
  always_ff @(posedge clk)
    if (rst) r_sv <= '0;
    else if (w_cap && !abort) r_sv[regAddr] <= 1'b1;
`else
  assign w_skip = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      regAddr <= '0;
      outValid <= 1'b0;
      outAddr <= '0;
      outData <= '0;
      outLast <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        outValid <= 1'b0;
      end else if (r_state == IDLE) begin
        if (start) begin
          regAddr <= FIRST;
          r_state <= SETUP;
        end
      end else if (w_adv) begin
        // end of window either stops or wraps to the first address for continuous scans
        outValid <= 1'b0;
        done <= w_last;
        regAddr <= w_last ? (continuous ? FIRST : regAddr) : regAddr + 5'd1;
        r_state <= (w_last && !continuous) ? IDLE : SETUP;
      end else if (w_cap) begin
        outData <= regData;
        outAddr <= regAddr;
        outLast <= w_last;
        outValid <= 1'b1;
        r_state <= OUT;
      end
    end
endmodule

// File: tb/tb_sm_reg_scanner.sv
// tb_sm_reg_scanner: directed checks of sm_reg_scanner; default window plus a 2-register continuous instance
module tb_sm_reg_scanner;
  logic clk = 1'b0;
  logic rst, start, abort, continuous, outReady;
  logic [4:0] regAddr, outAddr;
  logic [31:0] regData, outData;
  logic outValid, outLast, busy, done;
  logic b_start, b_cont, b_ready;
  logic [4:0] b_regAddr, b_outAddr;
  logic [31:0] b_regData, b_outData;
  logic b_outValid, b_outLast, b_busy, b_done;
  logic [31:0] mem [32];
  logic [31:0] cyc = '0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign regData = mem[regAddr];
  assign b_regData = cyc + 32'(b_regAddr);
  sm_reg_scanner dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .regAddr(regAddr), .regData(regData), .outValid(outValid), .outReady(outReady),
    .outAddr(outAddr), .outData(outData), .outLast(outLast), .busy(busy), .done(done)
  );
  sm_reg_scanner #(.FIRST_REG(4), .REG_COUNT(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(1'b0), .continuous(b_cont),
    .regAddr(b_regAddr), .regData(b_regData), .outValid(b_outValid), .outReady(b_ready),
    .outAddr(b_outAddr), .outData(b_outData), .outLast(b_outLast), .busy(b_busy), .done(b_done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic init_mem;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    mem[0] = 32'h5;
  endtask
  task automatic do_rst;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; outReady = 1'b0;
    b_start = 1'b0; b_cont = 1'b0; b_ready = 1'b0;
    init_mem;
    tick;
    tick;
    rst = 1'b0;
  endtask
  logic [4:0] bt_addr [64];
  logic [31:0] bt_data [64];
  logic bt_last [64];
  int n_beats, done_cyc;
  logic busy_at_done;
  task automatic run_scan;
    n_beats = 0;
    done_cyc = -1;
    busy_at_done = 1'b1;
    start = 1'b1;
    outReady = 1'b1;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      tick;
      start = 1'b0;
      if (outValid && n_beats < 64) begin
        bt_addr[n_beats] = outAddr;
        bt_data[n_beats] = outData;
        bt_last[n_beats] = outLast;
        n_beats++;
      end
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
      end
    end
  endtask
  typedef struct {
    logic st, ab, rd;
    logic ev, eb, ed, cra;
    logic [4:0] era;
    logic [31:0] eda;
  } vec_t;
  vec_t tv [8];
  initial begin
    int errs, found, lasts, nd;
    int dc [8];
    logic stable;
    tv[0] = '{1, 1, 0, 0, 0, 0, 1, 5'd0, 32'h0};
    tv[1] = '{1, 0, 0, 0, 1, 0, 1, 5'd0, 32'h0};
    tv[2] = '{1, 0, 0, 1, 1, 0, 1, 5'd0, 32'h5};
    tv[3] = '{0, 0, 0, 1, 1, 0, 1, 5'd0, 32'h5};
    tv[4] = '{0, 0, 1, 0, 1, 0, 1, 5'd1, 32'h0};
    tv[5] = '{0, 0, 1, 1, 1, 0, 1, 5'd1, 32'h101};
    tv[6] = '{0, 1, 1, 0, 0, 0, 0, 5'd0, 32'h0};
    tv[7] = '{0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0};
    do_rst;
    chk("rst regAddr", 32'(regAddr), 0);
    chk("rst outValid", 32'(outValid), 0);
    chk("rst outAddr", 32'(outAddr), 0);
    chk("rst outData", outData, 0);
    chk("rst outLast", 32'(outLast), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    for (int i = 0; i < 8; i++) begin
      start = tv[i].st; abort = tv[i].ab; outReady = tv[i].rd;
      tick;
      chk($sformatf("vec%0d outValid", i), 32'(outValid), 32'(tv[i].ev));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].eb));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tv[i].ed));
      if (tv[i].cra) chk($sformatf("vec%0d regAddr", i), 32'(regAddr), 32'(tv[i].era));
      if (tv[i].ev) begin
        chk($sformatf("vec%0d outAddr", i), 32'(outAddr), 32'(tv[i].era));
        chk($sformatf("vec%0d outData", i), outData, tv[i].eda);
        chk($sformatf("vec%0d outLast", i), 32'(outLast), 0);
      end
    end
    start = 1'b0; abort = 1'b0; outReady = 1'b0;
    do_rst;
    run_scan;
    chk("full beats", 32'(n_beats), 32);
    chk("full done cycle", 32'(done_cyc), 64);
    chk("full busy at done", 32'(busy_at_done), 0);
    chk("full beat0 data", bt_data[0], 32'h5);
    chk("full beat31 data", bt_data[31], 32'h11F);
    errs = 0;
    lasts = 0;
    for (int i = 0; i < 32; i++) begin
      if (bt_addr[i] !== 5'(i) || bt_data[i] !== mem[i]) errs++;
      if (bt_last[i] === 1'b1) lasts++;
    end
    chk("full addr/data seq errors", 32'(errs), 0);
    chk("full outLast count", 32'(lasts), 1);
    chk("full beat31 outLast", 32'(bt_last[31]), 1);
    do_rst;
    mem[3] = 32'hDEADBEEF;
    start = 1'b1; outReady = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick;
      start = 1'b0;
      if (outValid && outAddr == 5'd3) begin
        found = 1;
        outReady = 1'b0;
      end
    end
    chk("stall reach addr3", 32'(found), 1);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mem[3] = $urandom;
      tick;
      if (!(outValid === 1'b1 && outAddr === 5'd3 && outData === 32'hDEADBEEF)) stable = 1'b0;
    end
    mem[3] = 32'hDEADBEEF;
    chk("stall beat stable", 32'(stable), 1);
    outReady = 1'b1;
    tick;
    chk("stall accepted valid", 32'(outValid), 0);
    tick;
    chk("stall next outAddr", 32'(outAddr), 4);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (outValid && outAddr == 5'd7) begin
        found = 1;
        abort = 1'b1;
      end
      tick;
    end
    abort = 1'b0;
    chk("abort reach addr7", 32'(found), 1);
    chk("abort outValid", 32'(outValid), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    errs = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (outValid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("abort quiet after", 32'(errs), 0);
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick;
      start = 1'b0;
      if (outValid) found = 1;
    end
    chk("rescan beat seen", 32'(found), 1);
`ifdef SM_SCAN_DELTA_EN
    chk("rescan first addr", 32'(outAddr), 8);
`else
    chk("rescan first addr", 32'(outAddr), 0);
`endif
    abort = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b1; outReady = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick;
      start = 1'b0;
      if (regAddr == 5'd9 && busy && !outValid) found = 1;
    end
    chk("rst-mid reach setup9", 32'(found), 1);
    rst = 1'b1; start = 1'b1;
    tick;
    chk("rst-mid regAddr", 32'(regAddr), 0);
    chk("rst-mid outValid", 32'(outValid), 0);
    chk("rst-mid busy", 32'(busy), 0);
    tick;
    rst = 1'b0; start = 1'b0;
    tick;
    chk("rst start ignored busy", 32'(busy), 0);
    b_cont = 1'b1; b_ready = 1'b1; b_start = 1'b1;
    n_beats = 0; nd = 0; errs = 0;
    for (int c = 0; c < 16; c++) begin
      tick;
      b_start = 1'b0;
      if (b_outValid) begin
        if (b_outAddr !== ((n_beats % 2 == 0) ? 5'd4 : 5'd5)) errs++;
        if (b_outLast !== (b_outAddr == 5'd5)) errs++;
        n_beats++;
      end
      if (b_done && nd < 8) begin
        dc[nd] = c;
        nd++;
      end
    end
    chk("cont beats", 32'(n_beats), 8);
    chk("cont addr/last errors", 32'(errs), 0);
    chk("cont done count", 32'(nd), 3);
    chk("cont done0 cycle", 32'(dc[0]), 4);
    chk("cont done1 cycle", 32'(dc[1]), 8);
    chk("cont done2 cycle", 32'(dc[2]), 12);
    b_cont = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick;
      if (b_done) found = 1;
    end
    chk("cont stop done", 32'(found), 1);
    chk("cont stop busy", 32'(b_busy), 0);
    tick;
    chk("cont idle busy", 32'(b_busy), 0);
    chk("cont idle valid", 32'(b_outValid), 0);
`ifdef SM_SCAN_DELTA_EN
    do_rst;
    run_scan;
    chk("delta scan1 beats", 32'(n_beats), 32);
    mem[12] = mem[12] ^ 32'h1;
    run_scan;
    chk("delta scan2 beats", 32'(n_beats), 1);
    chk("delta scan2 addr", 32'(bt_addr[0]), 12);
    chk("delta scan2 last", 32'(bt_last[0]), 0);
    chk("delta scan2 done", 32'(done_cyc >= 0), 1);
    run_scan;
    chk("delta scan3 beats", 32'(n_beats), 0);
    chk("delta scan3 done", 32'(done_cyc >= 0), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
